// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
//
// Boot sequencer for the MIPS CPU. A program arrives as a valid/ready stream
// of instruction words. Each word is written to instruction memory at the next
// sequential word address, starting at 0. After the last word is written, the
// block holds the CPU in reset for RESET_HOLD cycles. It then releases reset
// and raises enable/start together. When the CPU reports halt, the block drops
// enable/start and sets a sticky done flag.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready is registered and is high only in LOAD.
// in_data is ignored whenever no transfer takes place.
//
// Ports
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   load_req           single-cycle request to load and boot (IDLE/HALTED only)
//   load_count         words to load, sampled with load_req; clamped to 2^ADDR_WIDTH
//   in_valid/in_data   instruction word stream
//   in_ready           loader accepts a word this cycle
//   imem_we/addr/wdata instruction memory write port (single-cycle strobes)
//   cpu_reset          CPU reset, active-high
//   cpu_enable         CPU enable
//   cpu_start          CPU start
//   halt               CPU halt indication (observed in RUN only)
//   busy               high in LOAD and HOLD
//   done               sticky, set on halt, cleared by the next load_req
//   dbg_state          current FSM state encoding
//
// RESET_HOLD must be at least 1.

module cpu_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_enable,
    output logic                  cpu_start,
    input  logic                  halt,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HOLD   = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [ADDR_WIDTH:0]   word_cnt, word_cnt_nx;   // words accepted so far
    logic [ADDR_WIDTH:0]   word_tgt, word_tgt_nx;   // clamped word count for this load
    logic [HOLD_W-1:0]     hold_cnt, hold_nx;
    logic [ADDR_WIDTH:0]   clamped_count;
    logic [ADDR_WIDTH:0]   word_cnt_inc;
    logic                  handshake;

    logic                  we_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic                  done_nx;
    logic                  ready_nx;
    logic                  busy_nx;
    logic                  creset_nx;
    logic                  run_nx;

    assign clamped_count = (load_count > CAPACITY) ? CAPACITY : load_count;
    assign word_cnt_inc  = word_cnt + CNT_ONE;
    assign handshake     = in_valid && in_ready;
    assign dbg_state     = state;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next values of all registered outputs and counters
    always_comb begin
        state_nx    = state;
        word_cnt_nx = word_cnt;
        word_tgt_nx = word_tgt;
        hold_nx     = hold_cnt;
        we_nx       = 1'b0;
        addr_nx     = imem_addr;
        wdata_nx    = imem_wdata;
        done_nx     = done;

        case (state)
            S_IDLE, S_HALTED: begin
                if (load_req) begin
                    word_cnt_nx = '0;
                    word_tgt_nx = clamped_count;
                    hold_nx     = '0;
                    done_nx     = 1'b0;
                    // A zero count skips loading and boots the existing image.
                    state_nx    = (clamped_count == '0) ? S_HOLD : S_LOAD;
                end
            end

            S_LOAD: begin
                if (handshake) begin
                    we_nx       = 1'b1;
                    addr_nx     = word_cnt[ADDR_WIDTH-1:0];
                    wdata_nx    = in_data;
                    word_cnt_nx = word_cnt_inc;
                    if (word_cnt_inc == word_tgt) begin
                        state_nx = S_HOLD;
                        hold_nx  = '0;
                    end
                end
            end

            S_HOLD: begin
                // Entered on edge j; RUN is registered on edge j+RESET_HOLD.
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = S_RUN;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (halt) begin
                    state_nx = S_HALTED;
                    done_nx  = 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Level outputs follow the state being entered so they change on the
        // same edge as the state itself.
        ready_nx  = (state_nx == S_LOAD);
        busy_nx   = (state_nx == S_LOAD) || (state_nx == S_HOLD);
        creset_nx = (state_nx == S_IDLE) || (state_nx == S_LOAD) || (state_nx == S_HOLD);
        run_nx    = (state_nx == S_RUN);
    end

    // Registered outputs and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt   <= '0;
            word_tgt   <= '0;
            hold_cnt   <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            word_cnt   <= word_cnt_nx;
            word_tgt   <= word_tgt_nx;
            hold_cnt   <= hold_nx;
            in_ready   <= ready_nx;
            imem_we    <= we_nx;
            imem_addr  <= addr_nx;
            imem_wdata <= wdata_nx;
            cpu_reset  <= creset_nx;
            cpu_enable <= run_nx;
            cpu_start  <= run_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
module tb_cpu_boot_loader;

    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int RH  = 4;
    localparam int CW  = AW + 1;
    localparam int CAP = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          load_req = 1'b0;
    logic [AW:0]   load_count = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          halt = 1'b0;
    logic          in_ready, imem_we, cpu_reset, cpu_enable, cpu_start, busy, done;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [2:0]    dbg_state;

    cpu_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(RH)) dut (
        .clock(clk), .reset(rst), .load_req(load_req), .load_count(load_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .halt(halt), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 loading, 2 holding CPU in reset, 3 running, 4 halted.
    int m_phase = 0;
    int m_left = 0, m_hold = 0, m_addr = 0, m_n = 0;
    logic e_ready = 0, e_we = 0, e_creset = 1, e_run = 0, e_busy = 0, e_done = 0;
    logic [AW+DW-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_addr = 0;
            e_ready = 0; e_we = 0; e_creset = 1; e_run = 0; e_busy = 0; e_done = 0;
            exp_q.delete();
        end else begin
            e_we = 0;
            case (m_phase)
                0, 4: if (load_req) begin
                    m_n = (int'(load_count) > CAP) ? CAP : int'(load_count);
                    e_done = 0; m_addr = 0; m_left = m_n;
                    if (m_n == 0) begin m_phase = 2; m_hold = RH; end
                    else m_phase = 1;
                end
                1: if (in_valid) begin
                    exp_q.push_back({AW'(m_addr), in_data});
                    e_we = 1;
                    m_addr++; m_left--;
                    if (m_left == 0) begin m_phase = 2; m_hold = RH; end
                end
                2: begin
                    m_hold--;
                    if (m_hold == 0) m_phase = 3;
                end
                3: if (halt) begin m_phase = 4; e_done = 1; end
                default: ;
            endcase
            e_ready  = (m_phase == 1);
            e_busy   = (m_phase == 1) || (m_phase == 2);
            e_creset = (m_phase <= 2);
            e_run    = (m_phase == 3);
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [DW-1:0]    tb_mem[CAP];
    int               wr_count = 0;
    logic [AW-1:0]    first_addr = '0;
    logic [AW+DW-1:0] w;

    always @(negedge clk) begin
        chk("in_ready", in_ready, e_ready);
        chk("imem_we", imem_we, e_we);
        chk("cpu_reset", cpu_reset, e_creset);
        chk("cpu_enable", cpu_enable, e_run);
        chk("cpu_start", cpu_start, e_run);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (imem_we) begin
            wr_count++;
            if (wr_count == 1) first_addr = imem_addr;
            tb_mem[imem_addr] = imem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("imem_addr", imem_addr, w[AW+DW-1:DW]);
                chk("imem_wdata", imem_wdata, w[DW-1:0]);
            end
        end
    end

    // ---------------- driver tasks (negedge aligned) ----------------
    logic [DW-1:0] feed_q[$];

    task automatic do_load_req(input int cnt);
        load_req = 1'b1;
        load_count = CW'(cnt);
        @(negedge clk);
        load_req = 1'b0;
        load_count = CW'($urandom);
    endtask

    // mode 0: continuous valid, 1: valid on alternate cycles, 2: random valid
    // with random (ignored) halt/load_req noise.
    task automatic feed(input int nwords, input int mode, input int limit, output int sent);
        int  c;
        bit  v, acc;
        sent = 0; c = 0;
        while (sent < nwords && c < limit) begin
            case (mode)
                0: v = 1'b1;
                1: v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data = (v && feed_q.size() > 0) ? feed_q[0] : $urandom;
            if (mode == 2) begin
                halt = ($urandom_range(0, 3) == 0);
                load_req = ($urandom_range(0, 5) == 0);
                load_count = CW'($urandom);
            end
            acc = v && in_ready;
            @(negedge clk);
            if (acc) begin
                sent++;
                if (feed_q.size() > 0) void'(feed_q.pop_front());
            end
            c++;
        end
        in_valid = 1'b0; in_data = $urandom; halt = 1'b0; load_req = 1'b0;
    endtask

    task automatic wait_run(output int k);
        k = 0;
        while (!cpu_enable && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!cpu_enable) chk("wait_run_timeout", 0, 1);
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    logic [DW-1:0] prog[4];
    int sent, k, cnt, exp_n;

    initial begin
        prog[0] = 32'h20080005; prog[1] = 32'h20090003;
        prog[2] = 32'h01095020; prog[3] = 32'hAC0A0000;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Gapped load of four words
        wr_count = 0;
        for (int i = 0; i < 4; i++) feed_q.push_back(prog[i]);
        do_load_req(4);
        feed(4, 1, 20, sent);
        chk("gap_sent", sent, 4);
        chk("gap_ready_low", in_ready, 0);
        wait_run(k);
        chk("gap_run_delay", k, 4);
        chk("gap_writes", wr_count, 4);
        for (int i = 0; i < 4; i++) chk("gap_mem", tb_mem[i], prog[i]);

        // Halt, then boot the existing image with a zero count
        repeat (2) @(negedge clk);
        pulse_halt();
        chk("halt_done", done, 1);
        chk("halt_enable", cpu_enable, 0);
        wr_count = 0;
        do_load_req(0);
        chk("zero_cpu_reset", cpu_reset, 1);
        chk("zero_done_clr", done, 0);
        wait_run(k);
        chk("zero_run_delay", k, 4);
        chk("zero_writes", wr_count, 0);

        // Halt and reload two words
        pulse_halt();
        chk("halt2_done", done, 1);
        wr_count = 0;
        do_load_req(2);
        chk("reload_done_clr", done, 0);
        chk("reload_cpu_reset", cpu_reset, 1);
        feed(2, 0, 10, sent);
        wait_run(k);
        chk("reload_writes", wr_count, 2);
        chk("reload_first_addr", first_addr, 0);

        // Reset in the middle of a load
        pulse_halt();
        do_load_req(8);
        feed(3, 0, 10, sent);
        #1 rst = 1'b1;
        #1;
        chk("midrst_imem_we", imem_we, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_count = 0;
        do_load_req(3);
        feed(3, 2, 60, sent);
        chk("midrst_reload_sent", sent, 3);
        wait_run(k);
        chk("midrst_first_addr", first_addr, 0);

        // Clamp: count 15 with capacity 8, valid held high throughout
        pulse_halt();
        wr_count = 0;
        do_load_req(15);
        feed(20, 0, 12, sent);
        chk("clamp_sent", sent, CAP);
        chk("clamp_ready_low", in_ready, 0);
        wait_run(k);
        chk("clamp_writes", wr_count, CAP);

        // Randomized boots
        for (int it = 0; it < 10; it++) begin
            pulse_halt();
            repeat ($urandom_range(0, 3)) begin
                halt = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            halt = 1'b0;
            cnt = $urandom_range(0, 2 * CAP - 1);
            exp_n = (cnt > CAP) ? CAP : cnt;
            wr_count = 0;
            do_load_req(cnt);
            if (exp_n > 0) begin
                feed(exp_n, 2, 100, sent);
                chk("rand_sent", sent, exp_n);
            end
            wait_run(k);
            chk("rand_writes", wr_count, exp_n);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
